arf_memory_sequencer: RTL and testbench

Sequencer that drives the address register file's control inputs (E, FunSel, RegSel, OutDSel) and a byte-wide memory port to perform 16-bit instruction fetch, stack push and stack pop. It sits between the control unit and the address register file. It turns a single request/response transaction into the per-cycle register increments and decrements and the memory byte accesses. The address register file's OutD is the memory address for every access this block issues.

---
 rtl/arf_memory_sequencer_if.sv | 33 +++
 rtl/arf_memory_sequencer.sv | 157 +++++++++++++++
 tb/tb_arf_memory_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arf_memory_sequencer_if.sv
// Bundle of the request/response handshake, address register file controls
// and byte-wide memory port shared by the control unit, sequencer, ARF and memory.
interface arf_memory_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        arf_E;
    logic [1:0]  arf_FunSel;
    logic [2:0]  arf_RegSel;
    logic [1:0]  arf_OutDSel;
    logic [15:0] arf_OutD;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport master (
        output req_valid, req_op, req_data, resp_ready, arf_OutD, mem_rdata,
        input  req_ready, resp_valid, resp_data, arf_E, arf_FunSel, arf_RegSel,
               arf_OutDSel, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport slave (
        input  req_valid, req_op, req_data, resp_ready, arf_OutD, mem_rdata,
        output req_ready, resp_valid, resp_data, arf_E, arf_FunSel, arf_RegSel,
               arf_OutDSel, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/arf_memory_sequencer.sv
// Turns FETCH/PUSH/POP requests into per-cycle ARF increment/decrement
// controls and byte memory accesses; all controls are registered Moore outputs.
module arf_memory_sequencer (
    input logic                   clk,
    input logic                   rst,
    arf_memory_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        F_RD0 = 4'd1,
        F_RD1 = 4'd2,
        F_CAP = 4'd3,
        W_HI  = 4'd4,
        W_LO  = 4'd5,
        P_INC = 4'd6,
        P_RD0 = 4'd7,
        P_RD1 = 4'd8,
        P_CAP = 4'd9,
        DONE  = 4'd10
    } state_t;

    typedef struct packed {
        logic       e;
        logic [1:0] fun_sel;
        logic [2:0] reg_sel;
        logic [1:0] outd_sel;
        logic       rd;
        logic       wr;
        logic [7:0] wdata;
    } ctl_t;

    // Control word for a given state; the request payload supplies the write byte.
    function automatic ctl_t decode_ctl(input state_t st, input logic [15:0] payload);
        ctl_t c;
        c = '0;
        case (st)
            F_RD0, F_RD1: begin
                c.rd = 1'b1; c.e = 1'b1; c.fun_sel = 2'b01; c.reg_sel = 3'b001; c.outd_sel = 2'b00;
            end
            W_HI: begin
                c.wr = 1'b1; c.wdata = payload[15:8]; c.outd_sel = 2'b01;
                c.e = 1'b1; c.fun_sel = 2'b00; c.reg_sel = 3'b100;
            end
            W_LO: begin
                c.wr = 1'b1; c.wdata = payload[7:0]; c.outd_sel = 2'b01;
                c.e = 1'b1; c.fun_sel = 2'b00; c.reg_sel = 3'b100;
            end
            P_INC: begin
                c.e = 1'b1; c.fun_sel = 2'b01; c.reg_sel = 3'b100;
            end
            P_RD0: begin
                c.rd = 1'b1; c.outd_sel = 2'b01; c.e = 1'b1; c.fun_sel = 2'b01; c.reg_sel = 3'b100;
            end
            P_RD1: begin
                c.rd = 1'b1; c.outd_sel = 2'b01;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t      state_r;
    state_t      next_s;
    ctl_t        ctl_r;
    ctl_t        ctl_next_s;
    logic [15:0] payload_s;
    logic [15:0] data_r;
    logic [7:0]  lo_r;
    logic        req_ready_r;
    logic        resp_valid_r;
    logic [15:0] resp_data_r;

    // Next-state decode; the opcode is consumed here so the state itself carries it.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        2'b00:   next_s = F_RD0;
                        2'b01:   next_s = W_HI;
                        2'b10:   next_s = P_INC;
                        default: next_s = DONE;
                    endcase
                end else begin
                    next_s = IDLE;
                end
            end
            F_RD0: next_s = F_RD1;
            F_RD1: next_s = F_CAP;
            F_CAP: next_s = DONE;
            W_HI:  next_s = W_LO;
            W_LO:  next_s = DONE;
            P_INC: next_s = P_RD0;
            P_RD0: next_s = P_RD1;
            P_RD1: next_s = P_CAP;
            P_CAP: next_s = DONE;
            DONE: begin
                if (bus.resp_ready) begin
                    next_s = IDLE;
                end else begin
                    next_s = DONE;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // On the accept edge the payload is not yet latched, so take it from the bus.
    always_comb begin
        payload_s  = (state_r == IDLE) ? bus.req_data : data_r;
        ctl_next_s = decode_ctl(next_s, payload_s);
    end

    // State register plus outputs pre-decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            ctl_r        <= '0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 16'h0000;
            data_r       <= 16'h0000;
            lo_r         <= 8'h00;
        end else begin
            state_r      <= next_s;
            ctl_r        <= ctl_next_s;
            req_ready_r  <= (next_s == IDLE);
            resp_valid_r <= (next_s == DONE);
            if (state_r == IDLE && bus.req_valid) begin
                data_r <= bus.req_data;
            end
            if (state_r == F_RD1 || state_r == P_RD1) begin
                lo_r <= bus.mem_rdata;
            end
            if (state_r == F_CAP || state_r == P_CAP) begin
                resp_data_r <= {bus.mem_rdata, lo_r};
            end else if ((next_s == DONE && state_r != DONE) || next_s == IDLE) begin
                resp_data_r <= 16'h0000;
            end
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.resp_valid  = resp_valid_r;
    assign bus.resp_data   = resp_data_r;
    assign bus.arf_E       = ctl_r.e;
    assign bus.arf_FunSel  = ctl_r.fun_sel;
    assign bus.arf_RegSel  = ctl_r.reg_sel;
    assign bus.arf_OutDSel = ctl_r.outd_sel;
    assign bus.mem_rd      = ctl_r.rd;
    assign bus.mem_wr      = ctl_r.wr;
    assign bus.mem_wdata   = ctl_r.wdata;
    assign bus.mem_addr    = bus.arf_OutD;

endmodule

// File: tb/tb_arf_memory_sequencer.sv
// Directed bench: behavioural ARF (PC/AR/SP) and byte memory around the sequencer.
module tb_arf_memory_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    arf_memory_sequencer_if bus();
    arf_memory_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    logic [15:0] pc = 16'h0000;
    logic [15:0] ar = 16'h0000;
    logic [15:0] sp = 16'h0000;
    logic [7:0]  mem [0:65535];
    logic [7:0]  rdata_r = 8'h00;
    logic        ld_pc = 1'b0, ld_sp = 1'b0, ld_mem = 1'b0;
    logic [15:0] ld_val = 16'h0000, ld_addr = 16'h0000;
    logic [7:0]  ld_byte = 8'h00;

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] rd_log [4];
    logic [15:0] wr_log [4];
    int n_rd, n_wr;
    logic any_act;

    assign bus.arf_OutD  = (bus.arf_OutDSel == 2'b00) ? pc : ((bus.arf_OutDSel == 2'b01) ? sp : ar);
    assign bus.mem_rdata = rdata_r;

    // ARF and memory models, with bench-side preload ports
    always @(posedge clk) begin
        if (ld_pc) pc <= ld_val;
        else if (bus.arf_E && bus.arf_RegSel[0])
            pc <= (bus.arf_FunSel == 2'b01) ? pc + 16'd1 : ((bus.arf_FunSel == 2'b00) ? pc - 16'd1 : pc);
        if (bus.arf_E && bus.arf_RegSel[1])
            ar <= (bus.arf_FunSel == 2'b01) ? ar + 16'd1 : ((bus.arf_FunSel == 2'b00) ? ar - 16'd1 : ar);
        if (ld_sp) sp <= ld_val;
        else if (bus.arf_E && bus.arf_RegSel[2])
            sp <= (bus.arf_FunSel == 2'b01) ? sp + 16'd1 : ((bus.arf_FunSel == 2'b00) ? sp - 16'd1 : sp);
        if (ld_mem) mem[ld_addr] <= ld_byte;
        else if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd) rdata_r <= mem[bus.mem_addr];
    end

    task automatic set_pc(input logic [15:0] v);
        ld_pc = 1'b1; ld_val = v;
        @(posedge clk); #1 ld_pc = 1'b0;
    endtask

    task automatic set_sp(input logic [15:0] v);
        ld_sp = 1'b1; ld_val = v;
        @(posedge clk); #1 ld_sp = 1'b0;
    endtask

    task automatic set_mem(input logic [15:0] a, input logic [7:0] b);
        ld_mem = 1'b1; ld_addr = a; ld_byte = b;
        @(posedge clk); #1 ld_mem = 1'b0;
    endtask

    // Issue one request with resp_ready high; records latency, response and accesses.
    task automatic run_txn(input logic [1:0] op, input logic [15:0] data,
                           output int lat, output logic [15:0] rdata);
        int k;
        n_rd = 0; n_wr = 0; any_act = 1'b0; lat = -1; rdata = 16'h0000;
        k = 0;
        while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_data = data; bus.resp_ready = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = 1'b0;
            any_act = any_act | bus.arf_E | bus.mem_rd | bus.mem_wr;
            if (bus.mem_rd) begin if (n_rd < 4) rd_log[n_rd] = bus.mem_addr; n_rd++; end
            if (bus.mem_wr) begin if (n_wr < 4) wr_log[n_wr] = bus.mem_addr; n_wr++; end
            if (bus.resp_valid) begin lat = c; rdata = bus.resp_data; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_resp: got valid=%b data=%h expected valid=0 data=0000", bus.resp_valid, bus.resp_data);
        end
        n_checks++;
        if ({bus.arf_E, bus.arf_FunSel, bus.arf_RegSel, bus.arf_OutDSel, bus.mem_rd, bus.mem_wr, bus.mem_wdata} !== 18'h0) begin
            n_fail++; $display("FAIL reset_controls: got E=%b fs=%b rs=%b od=%b rd=%b wr=%b wd=%h expected all zero",
                bus.arf_E, bus.arf_FunSel, bus.arf_RegSel, bus.arf_OutDSel, bus.mem_rd, bus.mem_wr, bus.mem_wdata);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int lat; logic [15:0] rd;
        set_pc(16'h0010); set_mem(16'h0010, 8'h34); set_mem(16'h0011, 8'h12);
        run_txn(2'b00, 16'h0000, lat, rd);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 4", lat); end
        n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL fetch_data: got %h expected 1234", rd); end
        n_checks++; if (pc !== 16'h0012) begin n_fail++; $display("FAIL fetch_pc: got %h expected 0012", pc); end
        n_checks++;
        if (n_rd !== 2 || rd_log[0] !== 16'h0010 || rd_log[1] !== 16'h0011) begin
            n_fail++; $display("FAIL fetch_addrs: got n=%0d %h %h expected n=2 0010 0011", n_rd, rd_log[0], rd_log[1]);
        end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_ready_after: got %b expected 1", bus.req_ready); end
    endtask

    task automatic test_push_pop();
        int lat; logic [15:0] rd;
        set_sp(16'h00FF);
        run_txn(2'b01, 16'hBEEF, lat, rd);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL push_latency: got %0d expected 3", lat); end
        n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL push_data: got %h expected 0000", rd); end
        n_checks++;
        if (mem[16'h00FF] !== 8'hBE || mem[16'h00FE] !== 8'hEF) begin
            n_fail++; $display("FAIL push_mem: got ff=%h fe=%h expected ff=be fe=ef", mem[16'h00FF], mem[16'h00FE]);
        end
        n_checks++; if (sp !== 16'h00FD) begin n_fail++; $display("FAIL push_sp: got %h expected 00fd", sp); end
        n_checks++;
        if (n_wr !== 2 || wr_log[0] !== 16'h00FF || wr_log[1] !== 16'h00FE) begin
            n_fail++; $display("FAIL push_addrs: got n=%0d %h %h expected n=2 00ff 00fe", n_wr, wr_log[0], wr_log[1]);
        end
        run_txn(2'b10, 16'h0000, lat, rd);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL pop_latency: got %0d expected 5", lat); end
        n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL pop_data: got %h expected beef", rd); end
        n_checks++; if (sp !== 16'h00FF) begin n_fail++; $display("FAIL pop_sp: got %h expected 00ff", sp); end
        n_checks++;
        if (n_rd !== 2 || rd_log[0] !== 16'h00FE || rd_log[1] !== 16'h00FF) begin
            n_fail++; $display("FAIL pop_addrs: got n=%0d %h %h expected n=2 00fe 00ff", n_rd, rd_log[0], rd_log[1]);
        end
    endtask

    task automatic test_fetch_wrap();
        int lat; logic [15:0] rd;
        set_pc(16'hFFFF); set_mem(16'hFFFF, 8'hAA); set_mem(16'h0000, 8'h55);
        run_txn(2'b00, 16'h0000, lat, rd);
        n_checks++; if (rd !== 16'h55AA) begin n_fail++; $display("FAIL wrap_data: got %h expected 55aa", rd); end
        n_checks++; if (pc !== 16'h0001) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0001", pc); end
    endtask

    task automatic test_back_to_back();
        int k;
        set_pc(16'h0020); set_sp(16'h0200);
        set_mem(16'h0020, 8'h78); set_mem(16'h0021, 8'h56);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_data = 16'h0000; bus.resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk); bus.req_valid = 1'b0;
        k = 1;
        while (!bus.resp_valid && k < 20) begin @(negedge clk); k++; end
        n_checks++; if (k !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d expected 4", k); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({bus.resp_valid, bus.req_ready, bus.resp_data} !== {1'b1, 1'b0, 16'h5678}) begin
                n_fail++; $display("FAIL bp_hold%0d: got valid=%b ready=%b data=%h expected valid=1 ready=0 data=5678",
                    i, bus.resp_valid, bus.req_ready, bus.resp_data);
            end
            if (i == 0) begin bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_data = 16'hA5C3; end
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || pc !== 16'h0022 || sp !== 16'h0200) begin
            n_fail++; $display("FAIL bp_idle_gap: got ready=%b valid=%b pc=%h sp=%h expected ready=1 valid=0 pc=0022 sp=0200",
                bus.req_ready, bus.resp_valid, pc, sp);
        end
        @(negedge clk); bus.req_valid = 1'b0;
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: got ready=%b expected 0", bus.req_ready); end
        k = 1;
        while (!bus.resp_valid && k < 20) begin @(negedge clk); k++; end
        n_checks++;
        if (k !== 3 || bus.resp_data !== 16'h0000) begin
            n_fail++; $display("FAIL bp_push_resp: got lat=%0d data=%h expected lat=3 data=0000", k, bus.resp_data);
        end
        @(negedge clk);
        n_checks++;
        if (sp !== 16'h01FE || mem[16'h0200] !== 8'hA5 || mem[16'h01FF] !== 8'hC3) begin
            n_fail++; $display("FAIL bp_push_effect: got sp=%h m200=%h m1ff=%h expected sp=01fe m200=a5 m1ff=c3",
                sp, mem[16'h0200], mem[16'h01FF]);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] rd;
        set_pc(16'h0030);
        set_mem(16'h0030, 8'h11); set_mem(16'h0031, 8'h22); set_mem(16'h0032, 8'h33);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); bus.req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.mem_rd !== 1'b1) begin n_fail++; $display("FAIL midrst_in_frd1: got mem_rd=%b expected 1", bus.mem_rd); end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.arf_E, bus.mem_rd, bus.mem_wr, bus.arf_RegSel} !== 8'b1000_0000) begin
            n_fail++; $display("FAIL midrst_async: got ready=%b valid=%b E=%b rd=%b wr=%b rs=%b expected ready=1 others 0",
                bus.req_ready, bus.resp_valid, bus.arf_E, bus.mem_rd, bus.mem_wr, bus.arf_RegSel);
        end
        @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b0 || pc !== 16'h0031) begin
            n_fail++; $display("FAIL midrst_state: got valid=%b pc=%h expected valid=0 pc=0031", bus.resp_valid, pc);
        end
        rst = 1'b1;
        @(negedge clk);
        run_txn(2'b00, 16'h0000, lat, rd);
        n_checks++;
        if (lat !== 4 || rd !== 16'h3322 || pc !== 16'h0033) begin
            n_fail++; $display("FAIL midrst_refetch: got lat=%0d data=%h pc=%h expected lat=4 data=3322 pc=0033", lat, rd, pc);
        end
    endtask

    task automatic test_illegal();
        int lat; logic [15:0] rd;
        set_pc(16'h0100); set_sp(16'h0300);
        run_txn(2'b11, 16'hFFFF, lat, rd);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL illegal_latency: got %0d expected 1", lat); end
        n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL illegal_data: got %h expected 0000", rd); end
        n_checks++;
        if (any_act !== 1'b0 || pc !== 16'h0100 || sp !== 16'h0300) begin
            n_fail++; $display("FAIL illegal_activity: got act=%b pc=%h sp=%h expected act=0 pc=0100 sp=0300", any_act, pc, sp);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_data = 16'h0000; bus.resp_ready = 1'b0;
        test_reset();
        test_fetch();
        test_push_pop();
        test_fetch_wrap();
        test_back_to_back();
        test_reset_mid();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
